// File: rtl/conv_stream_source_pkg.sv
// Shared sizing and state type for the convolution engine stream source.
package conv_pkg;
    localparam int XN  = 8;
    localparam int FN  = 4;
    localparam int DW  = 8;
    localparam int YW  = 18;
    localparam int YN  = XN - FN + 1;
    localparam int YCW = $clog2(YN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } src_state_t;
endpackage

// File: rtl/conv_stream_source_if.sv
// x/f master streams and y slave stream between the source and the conv engine.
interface conv_stream_source_if;
    import conv_pkg::*;

    logic signed [DW-1:0] m_data_out_x;
    logic                 m_valid_x;
    logic                 m_ready_x;
    logic signed [DW-1:0] m_data_out_f;
    logic                 m_valid_f;
    logic                 m_ready_f;
    logic signed [YW-1:0] s_data_in_y;
    logic                 s_valid_y;
    logic                 s_ready_y;

    modport master (
        output m_data_out_x, m_valid_x, input m_ready_x,
        output m_data_out_f, m_valid_f, input m_ready_f,
        input  s_data_in_y,  s_valid_y, output s_ready_y
    );

    modport slave (
        input  m_data_out_x, m_valid_x, output m_ready_x,
        input  m_data_out_f, m_valid_f, output m_ready_f,
        output s_data_in_y,  s_valid_y, input  s_ready_y
    );
endinterface

// File: rtl/conv_stream_source_tx_buf.sv
// Host-loaded register array streamed out once per run over a valid/ready master port.
module stream_tx_buf #(
    parameter  int DEPTH = 8,
    parameter  int W     = 8,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_addr,
    input  logic signed [W-1:0] wr_data,
    output logic signed [W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                full_d
);
    logic signed [W-1:0] mem_q [DEPTH];
    logic signed [W-1:0] mem_d [DEPTH];
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                pending;

    assign pending = (32'(cnt_q) < DEPTH);
    assign m_valid = run && pending;
    assign m_data  = pending ? mem_q[cnt_q[IW-1:0]] : '0;
    // full_d looks at the count after the coming edge so the FSM can leave RUN on that edge
    assign full_d  = (32'(cnt_d) == DEPTH);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (wr_en && !run && (32'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
        if (clear) begin
            cnt_d = '0;
        end else if (m_valid && m_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/conv_stream_source.sv
// Sends x and f to the conv engine on start and captures the returned y results.
//   state | meaning
//   IDLE  | host may load buffers; waiting for start
//   RUN   | streaming x/f out and collecting y until all counts are full
module conv_stream_source
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 h_wr_en,
    input  logic                 h_sel,
    input  logic [2:0]           h_addr,
    input  logic signed [DW-1:0] h_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    conv_stream_source_if.master st,
    input  logic [2:0]           r_addr,
    output logic signed [YW-1:0] r_data
);
    src_state_t           state_q, state_d;
    logic                 done_q, done_d;
    logic [YCW-1:0]       y_cnt_q, y_cnt_d;
    logic signed [YW-1:0] ybuf_q [YN];
    logic signed [YW-1:0] ybuf_d [YN];
    logic signed [YW-1:0] r_data_q, r_data_d;
    logic                 run, clear, x_full, f_full, y_full;

    assign run          = (state_q == RUN);
    assign clear        = !run && start;
    assign busy         = run;
    assign done         = done_q;
    assign r_data       = r_data_q;
    assign st.s_ready_y = run && (32'(y_cnt_q) < YN);
    assign y_full       = (32'(y_cnt_d) == YN);

    stream_tx_buf #(.DEPTH(XN), .W(DW)) u_x_buf (
        .clk, .reset, .clear, .run,
        .wr_en   (h_wr_en && !h_sel),
        .wr_addr (h_addr),
        .wr_data (h_data),
        .m_data  (st.m_data_out_x),
        .m_valid (st.m_valid_x),
        .m_ready (st.m_ready_x),
        .full_d  (x_full)
    );

    stream_tx_buf #(.DEPTH(FN), .W(DW)) u_f_buf (
        .clk, .reset, .clear, .run,
        .wr_en   (h_wr_en && h_sel),
        .wr_addr (h_addr[1:0]),
        .wr_data (h_data),
        .m_data  (st.m_data_out_f),
        .m_valid (st.m_valid_f),
        .m_ready (st.m_ready_f),
        .full_d  (f_full)
    );

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                done_d  = 1'b0;
            end
            RUN: if (x_full && f_full && y_full) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read uses the pre-edge buffer, so a same-cycle y write shows up one read later
    always_comb begin
        y_cnt_d  = y_cnt_q;
        ybuf_d   = ybuf_q;
        r_data_d = (32'(r_addr) < YN) ? ybuf_q[r_addr] : '0;
        if (clear) begin
            y_cnt_d = '0;
        end else if (st.s_ready_y && st.s_valid_y) begin
            ybuf_d[y_cnt_q] = st.s_data_in_y;
            y_cnt_d         = y_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            y_cnt_q  <= '0;
            r_data_q <= '0;
            for (int i = 0; i < YN; i++) begin
                ybuf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            y_cnt_q  <= y_cnt_d;
            r_data_q <= r_data_d;
            ybuf_q   <= ybuf_d;
        end
    end
endmodule
